// File: rtl/computie_bus_capture_ctrl_if.sv
// Bus-capture control interface: snooped record input, command pulses, byte stream out, status.
// The slave modport is the controller side; the master modport is the snooper/host side.
interface computie_bus_capture_ctrl_if #(
  parameter int RECORD_WIDTH = 65,
  parameter int DEPTH        = 32
);
  logic                     record_in_valid;
  logic [RECORD_WIDTH-1:0]  record_in;
  logic                     trigger_in;
  logic                     cmd_arm;
  logic                     cmd_abort;
  logic                     cmd_readout;
  logic [7:0]               tx_data;
  logic                     tx_valid;
  logic                     tx_ready;
  logic [2:0]               state_out;
  logic [$clog2(DEPTH):0]   fill_count;
  logic                     done;

  modport master (
    output record_in_valid, record_in, trigger_in,
    output cmd_arm, cmd_abort, cmd_readout,
    output tx_ready,
    input  tx_data, tx_valid, state_out, fill_count, done
  );

  modport slave (
    input  record_in_valid, record_in, trigger_in,
    input  cmd_arm, cmd_abort, cmd_readout,
    input  tx_ready,
    output tx_data, tx_valid, state_out, fill_count, done
  );
endinterface

// File: rtl/computie_bus_capture_ctrl.sv
// Bus-snooper capture sequencer: circular record buffer with pre-trigger history, then byte readout.
// Optional TIMESTAMP_EN: prefixes each stored record with a free-running 16-bit cycle stamp.
//
// state   | meaning
// IDLE    | records ignored, waiting for arm
// ARMED   | recording pre-trigger history, waiting for a qualified trigger
// POST    | recording the post-trigger window
// DONE    | capture frozen, waiting for readout or re-arm
// READOUT | streaming the capture out oldest record first, MSB byte first
module computie_bus_capture_ctrl #(
  parameter int RECORD_WIDTH = 65,
  parameter int DEPTH        = 32,
  parameter int PRE_TRIGGER  = 8
) (
  input  logic                       comm_clock,
  input  logic                       comm_reset,
  computie_bus_capture_ctrl_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
`ifdef TIMESTAMP_EN
  localparam int W = RECORD_WIDTH + 16;
`else
  localparam int W = RECORD_WIDTH;
`endif
  localparam int BYTES     = (W + 7) / 8;
  localparam int SW        = BYTES * 8;
  localparam int BIW       = $clog2(BYTES + 1);
  localparam int POST_INIT = DEPTH - PRE_TRIGGER - 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_POST    = 3'd2,
    S_DONE    = 3'd3,
    S_READOUT = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [W-1:0]     r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [FW-1:0]    r_fill;
  logic [FW-1:0]    r_post_left;
  logic [AW-1:0]    r_fetch_ptr;
  logic [FW-1:0]    r_fetch_left;
  logic [W-1:0]     r_rd_data;
  logic             r_rd_vld;
  logic [SW-1:0]    r_shift;
  logic [BIW-1:0]   r_byte_idx;
  logic             r_tx_valid;

  logic [W-1:0]     w_wr_word;
  logic             w_wr_en;
  logic             w_trig;
  logic             w_post_end;
  logic             w_arm;
  logic             w_readout_go;
  logic             w_in_ro;
  logic             w_tx_fire;
  logic             w_word_end;
  logic             w_load;
  logic             w_fetch;
  logic             w_ro_last;

`ifdef TIMESTAMP_EN
  logic [15:0]      r_timestamp;

  always_ff @(posedge comm_clock or negedge comm_reset) begin
    if (!comm_reset) r_timestamp <= '0;
    else             r_timestamp <= r_timestamp + 16'd1;
  end

  assign w_wr_word = {r_timestamp, bus.record_in};
`else
  assign w_wr_word = bus.record_in;
`endif

  assign w_wr_en      = bus.record_in_valid & ((r_state == S_ARMED) | (r_state == S_POST));
  assign w_trig       = (r_state == S_ARMED) & bus.record_in_valid & bus.trigger_in;
  assign w_post_end   = (r_state == S_POST) & bus.record_in_valid & (r_post_left == FW'(1));
  assign w_arm        = bus.cmd_arm & ~bus.cmd_abort;
  assign w_readout_go = (r_state == S_DONE) & bus.cmd_readout & ~bus.cmd_abort & ~bus.cmd_arm;
  assign w_in_ro      = (r_state == S_READOUT);

  // Prefetch: the next word is read while the current one shifts out, so records go out back to back.
  assign w_tx_fire    = r_tx_valid & bus.tx_ready;
  assign w_word_end   = w_tx_fire & (r_byte_idx == BIW'(BYTES - 1));
  assign w_load       = w_in_ro & r_rd_vld & (~r_tx_valid | w_word_end);
  assign w_fetch      = w_in_ro & (r_fetch_left != '0) & (~r_rd_vld | w_load);
  assign w_ro_last    = w_in_ro & w_word_end & ~r_rd_vld & (r_fetch_left == '0);

  always_ff @(posedge comm_clock or negedge comm_reset) begin
    if (!comm_reset) r_state <= S_IDLE;
    else             r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.cmd_abort) begin
      w_state_nxt = S_IDLE;
    end else if (bus.cmd_arm) begin
      w_state_nxt = S_ARMED;
    end else begin
      case (r_state)
        S_IDLE:    w_state_nxt = S_IDLE;
        S_ARMED:   if (w_trig) w_state_nxt = (POST_INIT == 0) ? S_DONE : S_POST;
        S_POST:    if (w_post_end) w_state_nxt = S_DONE;
        S_DONE:    if (bus.cmd_readout) w_state_nxt = (r_fill == '0) ? S_IDLE : S_READOUT;
        S_READOUT: if (w_ro_last) w_state_nxt = S_IDLE;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge comm_clock) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= w_wr_word;
  end

  always_ff @(posedge comm_clock or negedge comm_reset) begin
    if (!comm_reset) begin
      r_wr_ptr     <= '0;
      r_fill       <= '0;
      r_post_left  <= '0;
      r_fetch_ptr  <= '0;
      r_fetch_left <= '0;
      r_rd_data    <= '0;
      r_rd_vld     <= 1'b0;
      r_shift      <= '0;
      r_byte_idx   <= '0;
      r_tx_valid   <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        if (r_fill != FW'(DEPTH)) r_fill <= r_fill + FW'(1);
      end

      if (w_trig)
        r_post_left <= FW'(POST_INIT);
      else if ((r_state == S_POST) && bus.record_in_valid)
        r_post_left <= r_post_left - FW'(1);

      // A record arriving with arm is still written, but the fresh capture starts empty.
      if (w_arm) begin
        r_wr_ptr <= '0;
        r_fill   <= '0;
      end

      if (bus.cmd_abort || bus.cmd_arm) begin
        r_tx_valid   <= 1'b0;
        r_rd_vld     <= 1'b0;
        r_fetch_left <= '0;
      end else if (w_readout_go) begin
        r_fetch_ptr  <= r_wr_ptr - r_fill[AW-1:0];
        r_fetch_left <= r_fill;
        r_rd_vld     <= 1'b0;
        r_tx_valid   <= 1'b0;
      end else if (w_in_ro) begin
        if (w_fetch) begin
          r_rd_data    <= r_mem[r_fetch_ptr];
          r_fetch_ptr  <= r_fetch_ptr + AW'(1);
          r_fetch_left <= r_fetch_left - FW'(1);
          r_rd_vld     <= 1'b1;
        end else if (w_load) begin
          r_rd_vld <= 1'b0;
        end

        if (w_load) begin
          r_shift    <= SW'(r_rd_data);
          r_byte_idx <= '0;
          r_tx_valid <= 1'b1;
        end else if (w_word_end) begin
          r_tx_valid <= 1'b0;
        end else if (w_tx_fire) begin
          r_shift    <= r_shift << 8;
          r_byte_idx <= r_byte_idx + BIW'(1);
        end
      end
    end
  end

  assign bus.tx_data    = r_shift[SW-1 -: 8];
  assign bus.tx_valid   = r_tx_valid;
  assign bus.state_out  = r_state;
  assign bus.fill_count = r_fill;
  assign bus.done       = (r_state == S_DONE);

endmodule

// File: tb/tb_computie_bus_capture_ctrl.sv
// Directed/random bench for computie_bus_capture_ctrl; the expected byte stream is rebuilt from
// a list of every record written since arm (last DEPTH kept, oldest first, MSB byte first).
module tb_computie_bus_capture_ctrl;
  localparam int RW     = 65;
  localparam int DEPTH  = 32;
  localparam int PRE    = 8;
`ifdef TIMESTAMP_EN
  localparam int WT     = RW + 16;
`else
  localparam int WT     = RW;
`endif
  localparam int NB     = (WT + 7) / 8;
  localparam int POST_N = DEPTH - PRE - 1;

  logic comm_clock = 1'b0;
  logic comm_reset = 1'b0;
  always #5 comm_clock = ~comm_clock;

  computie_bus_capture_ctrl_if #(.RECORD_WIDTH(RW), .DEPTH(DEPTH)) bus ();

  computie_bus_capture_ctrl #(.RECORD_WIDTH(RW), .DEPTH(DEPTH), .PRE_TRIGGER(PRE)) dut (
    .comm_clock (comm_clock),
    .comm_reset (comm_reset),
    .bus        (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;
  logic [15:0]  cyc;
  logic [127:0] hist[$];
  logic [7:0]   exp_q[$];
  logic [7:0]   act_q[$];

  always @(posedge comm_clock or negedge comm_reset)
    if (!comm_reset) cyc <= '0;
    else             cyc <= cyc + 16'd1;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge comm_clock);
    #1;
  endtask

  task automatic arm();
    bus.cmd_arm = 1'b1;
    tick();
    bus.cmd_arm = 1'b0;
    hist.delete();
    check("arm_state", bus.state_out, 1);
    check("arm_fill", bus.fill_count, 0);
  endtask

  task automatic send_rec(input bit trig, input bit logged);
    logic [RW-1:0]  r;
    logic [127:0]   e;
    r = RW'({$urandom(), $urandom(), $urandom()});
    e = '0;
    e[RW-1:0] = r;
`ifdef TIMESTAMP_EN
    e[RW +: 16] = cyc;
`endif
    bus.record_in       = r;
    bus.record_in_valid = 1'b1;
    bus.trigger_in      = trig;
    if (logged) hist.push_back(e);
    tick();
    bus.record_in_valid = 1'b0;
    bus.trigger_in      = 1'b0;
  endtask

  task automatic build_exp();
    int n;
    int first;
    n = hist.size();
    first = (n > DEPTH) ? n - DEPTH : 0;
    exp_q.delete();
    for (int i = first; i < n; i++)
      for (int k = NB - 1; k >= 0; k--)
        exp_q.push_back(8'(hist[i] >> (8 * k)));
  endtask

  function automatic logic [127:0] rd_word(input int r);
    logic [127:0] w;
    w = '0;
    for (int k = 0; k < NB; k++)
      if (r * NB + k < act_q.size()) w = (w << 8) | 128'(act_q[r * NB + k]);
    return w;
  endfunction

  // mode 0: sink always ready; mode 1: random ready plus a forced 5-cycle stall
  task automatic run_readout(input int mode);
    int n;
    logic [7:0] pd;
    bit pv;
    bit pr;
    n  = 0;
    pv = 1'b0;
    pr = 1'b1;
    pd = '0;
    act_q.delete();
    bus.cmd_readout = 1'b1;
    tick();
    bus.cmd_readout = 1'b0;
    check("ro_state", bus.state_out, 4);
    while (!(bus.state_out == 3'd0 && !bus.tx_valid) && n < 4000) begin
      if (n == 1) check("lat_c1_valid", bus.tx_valid, 0);
      if (n == 2) check("lat_c2_valid", bus.tx_valid, 1);
      if (pv && !pr) begin
        check("bp_valid_hold", bus.tx_valid, 1);
        check("bp_data_hold", bus.tx_data, pd);
      end
      if (mode == 0)                bus.tx_ready = 1'b1;
      else if (n >= 20 && n < 25)   bus.tx_ready = 1'b0;
      else                          bus.tx_ready = ($urandom_range(0, 3) != 0);
      if (bus.tx_valid && bus.tx_ready) act_q.push_back(bus.tx_data);
      pv = bus.tx_valid;
      pr = bus.tx_ready;
      pd = bus.tx_data;
      tick();
      n++;
    end
    bus.tx_ready = 1'b0;
    check("ro_in_budget", n < 4000, 1);
    check("ro_end_state", bus.state_out, 0);
  endtask

  task automatic cmp_stream(input string tag);
    int bad;
    bad = 0;
    build_exp();
    check({tag, "_bytes"}, act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (bad == 0 && (i >= act_q.size() || act_q[i] !== exp_q[i])) bad = i + 1;
    check({tag, "_first_bad_byte_plus1"}, bad, 0);
  endtask

  task automatic fill_to_done(input int pre, input int t_extra);
    for (int i = 0; i < pre; i++) send_rec(1'b0, 1'b1);
    send_rec(1'b1, 1'b1);
    for (int i = 0; i < t_extra; i++) send_rec(1'($urandom_range(0, 1)), 1'b1);
  endtask

  initial begin
    logic [127:0] w;
    logic [15:0]  ts0;
    logic [15:0]  ts1;
    int cnt;
    int g;
    bus.record_in_valid = 1'b0;
    bus.record_in       = '0;
    bus.trigger_in      = 1'b0;
    bus.cmd_arm         = 1'b0;
    bus.cmd_abort       = 1'b0;
    bus.cmd_readout     = 1'b0;
    bus.tx_ready        = 1'b0;
    tick(); tick();
    comm_reset = 1'b1;
    tick();

    check("rst_state", bus.state_out, 0);
    check("rst_fill", bus.fill_count, 0);
    check("rst_done", bus.done, 0);
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_tx_data", bus.tx_data, 0);

    send_rec(1'b1, 1'b0);
    send_rec(1'b0, 1'b0);
    check("idle_ignores_fill", bus.fill_count, 0);
    check("idle_ignores_state", bus.state_out, 0);

    // early trigger: 3 pre records, trigger on the 4th, then the post window
    arm();
    fill_to_done(3, POST_N - 1);
    check("early_post_state", bus.state_out, 2);
    send_rec(1'b1, 1'b1);
    check("early_done_state", bus.state_out, 3);
    check("early_done_flag", bus.done, 1);
    check("early_fill", bus.fill_count, 3 + 1 + POST_N);
    run_readout(0);
    check("early_byte_total", act_q.size(), 27 * NB);
    cmp_stream("early");
    w = rd_word(0);
    check("early_first_record", w, hist[0]);
    check("early_fill_retained", bus.fill_count, 27);

    // wrapped history with random backpressure
    arm();
    fill_to_done(39, POST_N);
    check("wrap_done", bus.done, 1);
    check("wrap_fill", bus.fill_count, DEPTH);
    run_readout(1);
    check("wrap_byte_total", act_q.size(), DEPTH * NB);
    cmp_stream("wrap");
    w = rd_word(0);
    check("wrap_first_record", w, hist[hist.size() - DEPTH]);
    w = rd_word(PRE);
    check("wrap_9th_is_trigger", w, hist[39]);

    // abort after 10 bytes; a later readout command is ignored
    arm();
    fill_to_done(0, POST_N);
    bus.cmd_readout = 1'b1;
    tick();
    bus.cmd_readout = 1'b0;
    bus.tx_ready = 1'b1;
    cnt = 0;
    g = 0;
    while (cnt < 10 && g < 200) begin
      if (bus.tx_valid) cnt++;
      tick();
      g++;
    end
    check("abort_reached_10", cnt, 10);
    bus.cmd_abort = 1'b1;
    tick();
    bus.cmd_abort = 1'b0;
    check("abort_tx_valid", bus.tx_valid, 0);
    check("abort_state", bus.state_out, 0);
    check("abort_done", bus.done, 0);
    bus.cmd_readout = 1'b1;
    tick();
    bus.cmd_readout = 1'b0;
    check("abort_ro_ignored_state", bus.state_out, 0);
    tick(); tick();
    check("abort_ro_ignored_valid", bus.tx_valid, 0);
    bus.tx_ready = 1'b0;

    // command priority: arm beats readout, abort beats arm
    arm();
    fill_to_done(2, POST_N);
    check("prio_done", bus.state_out, 3);
    bus.cmd_arm = 1'b1;
    bus.cmd_readout = 1'b1;
    tick();
    bus.cmd_arm = 1'b0;
    bus.cmd_readout = 1'b0;
    check("prio_arm_over_ro", bus.state_out, 1);
    check("prio_arm_fill", bus.fill_count, 0);
    bus.cmd_abort = 1'b1;
    bus.cmd_arm = 1'b1;
    tick();
    bus.cmd_abort = 1'b0;
    bus.cmd_arm = 1'b0;
    check("prio_abort_over_arm", bus.state_out, 0);

    // arm during readout abandons it
    arm();
    fill_to_done(5, POST_N);
    bus.cmd_readout = 1'b1;
    tick();
    bus.cmd_readout = 1'b0;
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("rearm_mid_valid_before", bus.tx_valid, 1);
    bus.cmd_arm = 1'b1;
    tick();
    bus.cmd_arm = 1'b0;
    hist.delete();
    check("rearm_state", bus.state_out, 1);
    check("rearm_tx_valid", bus.tx_valid, 0);
    check("rearm_fill", bus.fill_count, 0);
    bus.tx_ready = 1'b0;

`ifdef TIMESTAMP_EN
    send_rec(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    send_rec(1'b1, 1'b1);
    for (int i = 0; i < POST_N; i++) send_rec(1'b0, 1'b1);
    check("ts_done", bus.state_out, 3);
    run_readout(0);
    check("ts_byte_total", act_q.size(), (POST_N + 2) * 11);
    cmp_stream("ts");
    w = rd_word(0);
    ts0 = w[RW +: 16];
    w = rd_word(1);
    ts1 = w[RW +: 16];
    check("ts_delta", 16'(ts1 - ts0), 5);
    arm();
`endif

    // asynchronous reset in the middle of a readout
    fill_to_done(1, POST_N);
    bus.cmd_readout = 1'b1;
    tick();
    bus.cmd_readout = 1'b0;
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    #2;
    comm_reset = 1'b0;
    #1;
    check("arst_state", bus.state_out, 0);
    check("arst_tx_valid", bus.tx_valid, 0);
    check("arst_tx_data", bus.tx_data, 0);
    check("arst_fill", bus.fill_count, 0);
    check("arst_done", bus.done, 0);
    bus.tx_ready = 1'b0;
    tick();
    comm_reset = 1'b1;
    tick();
    check("arst_after_state", bus.state_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
